mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
// - Main control FSM for the multicycle MIPS core; sits directly upstream of the datapath.
// - Decodes op/funct of the latched instruction and sequences the datapath strobes.
// - Drives all datapath strobes: pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite,
//   alusrcA, alusrcB, pcsrc, alucontrol.
// - Moore FSM. Exceptions: pcEn depends on zero; alucontrol depends on funct in RTYPEEX.
// PARAMETERS
// - STATE_W          4  width of the state debug output; must be >= 4
// - ILLEGAL_OP_HALT  0  on an unknown opcode: 1 = park in HALT until reset, 0 = return to FETCH
// PORTS
// - clk         in   1  rising-edge clock
// - reset_n     in   1  asynchronous, active-low reset
// - op          in   6  instr[31:26]
// - funct       in   6  instr[5:0]
// - zero        in   1  ALU zero flag from datapath
// - pcEn        out  1  PC register enable
// - IorD        out  1  memory address select: 0 = pc, 1 = aluout
// - memwrite    out  1  memory write strobe
// - IRwrite     out  1  instruction register load
// - regdst      out  1  write register select: 0 = rt, 1 = rd
// - memtoreg    out  1  writeback select: 0 = aluout, 1 = data
// - regwrite    out  1  register file write strobe
// - alusrcA     out  1  ALU A select: 0 = pc, 1 = regA
// - alusrcB     out  2  ALU B select: 00 = regB, 01 = 4, 10 = signimm, 11 = signimm<<2
// - pcsrc       out  2  next-PC select: 00 = aluresult, 01 = aluout, 10 = pcjump
// - alucontrol  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
// - illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported
// - state       out  STATE_W  current state encoding (debug)
// BEHAVIOUR
// - State codes: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTYPEEX=6 RTYPEWB=7
//   BEQEX=8 ADDIEX=9 ADDIWB=10 JEX=11 HALT=15.
// - Any strobe not listed for a state is 0. Unlisted selects are 0; alucontrol defaults to 010.
// - pcEn = pcwrite | (branch & zero), where pcwrite and branch are internal.
// - Per-state outputs:
//   - FETCH: IorD=0, alusrcA=0, alusrcB=01, add, pcsrc=00, IRwrite=1, pcwrite=1.
//   - DECODE: alusrcA=0, alusrcB=11, add (branch target into aluout).
//   - MEMADR: alusrcA=1, alusrcB=10, add.
//   - MEMRD: IorD=1.
//   - MEMWB: regdst=0, memtoreg=1, regwrite=1.
//   - MEMWR: IorD=1, memwrite=1.
//   - RTYPEEX: alusrcA=1, alusrcB=00; funct 100000->010, 100010->110, 100100->000,
//     100101->001, 101010->111, other->010.
//   - RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
//   - BEQEX: alusrcA=1, alusrcB=00, sub, pcsrc=01, branch=1.
//   - JEX: pcsrc=10, pcwrite=1.
//   - HALT: all strobes 0.
// - Transitions:
//   - FETCH->DECODE.
//   - DECODE by op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX;
//     000010 -> JEX; 001000 -> ADDIEX (macro only); else illegal.
//   - MEMADR -> MEMRD (lw) or MEMWR (sw). MEMRD->MEMWB.
//   - RTYPEEX->RTYPEWB. Every terminal state -> FETCH. HALT->HALT.
// - Cycles per instruction: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
// - Illegal op: illegal_op=1 in DECODE; next state is HALT if ILLEGAL_OP_HALT=1, else FETCH.
//   No write strobes are asserted for the instruction.
// - Reset (reset_n low, at any time, including mid-instruction):
//   - state -> FETCH immediately.
//   - pcEn, IRwrite, memwrite, regwrite, illegal_op forced to 0 while reset_n is low.
//   - Selects show FETCH values.
//   - First FETCH strobes occur on the first edge after reset_n rises.
// - zero is sampled only in BEQEX; a zero toggle in other states has no effect.
// CONFIGURATION
// - MC_CTRL_ADDI_EN defined:
//   - op 001000 decodes to ADDIEX -> ADDIWB.
//   - ADDIEX: alusrcA=1, alusrcB=10, add.
//   - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
// - MC_CTRL_ADDI_EN undefined: op 001000 is illegal; ADDIEX/ADDIWB codes are unreachable.
// TESTING
// - lw (op=100011) from reset: states 0,1,2,3,4,0.
//   -> IRwrite=1 and pcEn=1 in cycle 1; IorD=1 in cycle 4; regwrite=1, memtoreg=1 in cycle 5.
// - sw (op=101011): states 0,1,2,5 -> memwrite=1, IorD=1 exactly in cycle 4; regwrite never 1.
// - R-type sub (op=0, funct=100010): RTYPEEX drives alucontrol=110, alusrcB=00;
//   RTYPEWB drives regdst=1, regwrite=1.
// - beq (op=000100), zero=1 -> pcEn=1, pcsrc=01 in BEQEX.
//   Repeat with zero=0 -> pcEn=0; 3 cycles either way.
// - j (op=000010): JEX drives pcsrc=10, pcEn=1, then FETCH.
// - op=111111, ILLEGAL_OP_HALT=1: illegal_op pulses once, state=15 and holds with all strobes 0.
//   Asserting reset_n=0 mid-MEMRD returns the FSM to FETCH with no write strobes.
// - addi (op=001000): with MC_CTRL_ADDI_EN, 4 cycles, regwrite=1 with regdst=0;
//   without the macro, illegal_op=1.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller -- main control FSM of the multicycle MIPS core.
//
// Decodes op/funct of the latched instruction and sequences every datapath
// strobe. Moore machine, except that pcEn also depends on zero (branch) and
// alucontrol depends on funct in RTYPEEX.
//
// Optional feature macro: MC_CTRL_ADDI_EN
//   defined   -> op 001000 (addi) runs ADDIEX -> ADDIWB
//   undefined -> op 001000 is treated as an unsupported opcode
//
// Parameters:
//   STATE_W          width of the state debug output (>= 4)
//   ILLEGAL_OP_HALT  1 = unknown opcode parks in HALT until reset, 0 = back to FETCH
//
// Ports:
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   op, funct, zero    instr[31:26], instr[5:0], ALU zero flag
//   pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite,
//   alusrcA, alusrcB, pcsrc, alucontrol   datapath strobes and selects
//   illegal_op         one-cycle pulse in DECODE on an unsupported opcode
//   state              current state encoding (debug)
module mc_controller #(
  parameter int STATE_W         = 4,
  parameter bit ILLEGAL_OP_HALT = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcEn,
  output logic               IorD,
  output logic               memwrite,
  output logic               IRwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrcA,
  output logic [1:0]         alusrcB,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;

  // Ungated versions of the strobes that must be forced low during reset.
  logic pcwrite_c, branch_c, irwrite_c, memwrite_c, regwrite_c, illegal_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    IorD       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrcA    = 1'b0;
    alusrcB    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        alusrcB   = 2'b01;
        irwrite_c = 1'b1;
        pcwrite_c = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into aluout while decoding.
        alusrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            illegal_c = 1'b1;
            state_d   = ILLEGAL_OP_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        memwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrcA = 1'b1;
        case (funct)
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQEX: begin
        alusrcA    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch_c   = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      S_JEX: begin
        pcsrc     = 2'b10;
        pcwrite_c = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      // Unreachable codes (including ADDIEX/ADDIWB when addi is disabled).
      default: state_d = S_FETCH;
    endcase
  end

  // State is already FETCH while reset_n is low, so selects show FETCH values;
  // the enables are gated so nothing is written until reset_n rises.
  assign pcEn       = reset_n & (pcwrite_c | (branch_c & zero));
  assign IRwrite    = reset_n & irwrite_c;
  assign memwrite   = reset_n & memwrite_c;
  assign regwrite   = reset_n & regwrite_c;
  assign illegal_op = reset_n & illegal_c;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA;
  logic [1:0] alusrcB, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  mc_controller #(.STATE_W(4), .ILLEGAL_OP_HALT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcEn(pcEn), .IorD(IorD), .memwrite(memwrite), .IRwrite(IRwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrcA(alusrcA), .alusrcB(alusrcB), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {pcEn,IorD,memwrite,IRwrite, regdst,memtoreg,regwrite,alusrcA,
  //  alusrcB[1:0],pcsrc[1:0], alucontrol[2:0],illegal_op}
  logic [15:0] outs;
  assign outs = {pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA,
                 alusrcB, pcsrc, alucontrol, illegal_op};

  localparam logic [15:0] V_RST     = 16'h0044;
  localparam logic [15:0] V_FETCH   = 16'h9044;
  localparam logic [15:0] V_DECODE  = 16'h00C4;
  localparam logic [15:0] V_DEC_ILL = 16'h00C5;
  localparam logic [15:0] V_MEMADR  = 16'h0184;
  localparam logic [15:0] V_MEMRD   = 16'h4004;
  localparam logic [15:0] V_MEMWB   = 16'h0604;
  localparam logic [15:0] V_MEMWR   = 16'h6004;
  localparam logic [15:0] V_RTWB    = 16'h0A04;
  localparam logic [15:0] V_BEQ_T   = 16'h811C;
  localparam logic [15:0] V_BEQ_N   = 16'h011C;
  localparam logic [15:0] V_JEX     = 16'h8024;
  localparam logic [15:0] V_HALT    = 16'h0004;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [15:0] V_ADDIWB  = 16'h0204;
`endif

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Check state and all outputs at the current sample point, then move to the
  // next negedge (one clock later).
  task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [15:0] v);
    check_val({tag, "/state"}, {12'd0, state}, {12'd0, st});
    check_val({tag, "/outs"}, outs, v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic r_type(input string tag, input logic [5:0] f, input logic [15:0] ex_vec);
    op = 6'b000000; funct = f;
    expect_cyc({tag, "/fetch"}, 4'd0, V_FETCH);
    expect_cyc({tag, "/decode"}, 4'd1, V_DECODE);
    zero = 1'b1;  // must not affect pcEn outside BEQEX
    expect_cyc({tag, "/ex"}, 4'd6, ex_vec);
    zero = 1'b0;
    expect_cyc({tag, "/wb"}, 4'd7, V_RTWB);
    $display("txn %s funct=%b done", tag, f);
  endtask

  initial begin
    // Reset state, held across a clock edge.
    op = 6'b100011;
    @(negedge clk);
    check_val("rst/state", {12'd0, state}, 16'd0);
    check_val("rst/outs", outs, V_RST);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    // lw
    expect_cyc("lw/fetch", 4'd0, V_FETCH);
    expect_cyc("lw/decode", 4'd1, V_DECODE);
    expect_cyc("lw/memadr", 4'd2, V_MEMADR);
    expect_cyc("lw/memrd", 4'd3, V_MEMRD);
    expect_cyc("lw/memwb", 4'd4, V_MEMWB);
    $display("txn lw done");
    // sw
    op = 6'b101011;
    expect_cyc("sw/fetch", 4'd0, V_FETCH);
    expect_cyc("sw/decode", 4'd1, V_DECODE);
    expect_cyc("sw/memadr", 4'd2, V_MEMADR);
    expect_cyc("sw/memwr", 4'd5, V_MEMWR);
    $display("txn sw done");
    // R-type variants
    r_type("sub", 6'b100010, 16'h010C);
    r_type("add", 6'b100000, 16'h0104);
    r_type("and", 6'b100100, 16'h0100);
    r_type("or",  6'b100101, 16'h0102);
    r_type("slt", 6'b101010, 16'h010E);
    r_type("oth", 6'b000111, 16'h0104);
    // beq taken / not taken
    op = 6'b000100; zero = 1'b1;
    expect_cyc("beqT/fetch", 4'd0, V_FETCH);
    expect_cyc("beqT/decode", 4'd1, V_DECODE);
    expect_cyc("beqT/ex", 4'd8, V_BEQ_T);
    $display("txn beq zero=1 done");
    zero = 1'b0;
    expect_cyc("beqN/fetch", 4'd0, V_FETCH);
    expect_cyc("beqN/decode", 4'd1, V_DECODE);
    expect_cyc("beqN/ex", 4'd8, V_BEQ_N);
    $display("txn beq zero=0 done");
    // j
    op = 6'b000010;
    expect_cyc("j/fetch", 4'd0, V_FETCH);
    expect_cyc("j/decode", 4'd1, V_DECODE);
    expect_cyc("j/ex", 4'd11, V_JEX);
    $display("txn j done");
    // addi
    op = 6'b001000;
    expect_cyc("addi/fetch", 4'd0, V_FETCH);
`ifdef MC_CTRL_ADDI_EN
    expect_cyc("addi/decode", 4'd1, V_DECODE);
    expect_cyc("addi/ex", 4'd9, V_MEMADR);
    expect_cyc("addi/wb", 4'd10, V_ADDIWB);
    $display("txn addi done");
    op = 6'b111111;
    expect_cyc("ill/fetch", 4'd0, V_FETCH);
`endif
    expect_cyc("ill/decode", 4'd1, V_DEC_ILL);
    expect_cyc("ill/halt0", 4'd15, V_HALT);
    expect_cyc("ill/halt1", 4'd15, V_HALT);
    expect_cyc("ill/halt2", 4'd15, V_HALT);
    $display("txn illegal op=%b done", op);
    // Reset out of HALT.
    reset_n = 1'b0;
    #1;
    check_val("rsthalt/state", {12'd0, state}, 16'd0);
    check_val("rsthalt/outs", outs, V_RST);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    // lw interrupted by reset in MEMRD (asynchronous, mid-cycle)
    op = 6'b100011;
    expect_cyc("lwR/fetch", 4'd0, V_FETCH);
    expect_cyc("lwR/decode", 4'd1, V_DECODE);
    expect_cyc("lwR/memadr", 4'd2, V_MEMADR);
    check_val("lwR/memrd", outs, V_MEMRD);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("lwR/rst_state", {12'd0, state}, 16'd0);
    check_val("lwR/rst_outs", outs, V_RST);
    @(posedge clk);
    @(negedge clk);
    check_val("lwR/rst_hold_state", {12'd0, state}, 16'd0);
    check_val("lwR/rst_hold_outs", outs, V_RST);
    reset_n = 1'b1;
    #1;
    expect_cyc("post/fetch", 4'd0, V_FETCH);
    expect_cyc("post/decode", 4'd1, V_DECODE);
    $display("txn reset mid-lw done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
